// File: rtl/rx_ber_checker.sv
// Receive-side BER checker: decimate, hard-slice, find latency to the reference PRBS, count bits/errors.
// Latency: o_state/o_locked/o_latency move on the edge after the tick that closes the last search window;
// counters 1 clock after their tick. Backpressure: none; i_enable=0 freezes every piece of state.
//
// Ports:
//   clock, i_reset (async, active-low)   - clock and reset
//   i_enable                             - processing enable
//   i_phase                              - decimation phase, 0..OS_FACTOR-1
//   i_sample                             - signed filtered sample, S(8,6)
//   i_ref_bit                            - reference PRBS bit, sampled on the symbol tick
//   o_locked, o_latency, o_state         - lock status, chosen delay in symbols, FSM state
//   o_bit_count, o_err_count             - saturating symbol / mismatch counts while locked
//
// Optional build macro RX_RELOCK_EN: while locked, every BUF_LEN-tick window with more than
// RELOCK_THR errors sends the block back to SEARCH with counters cleared. Undefined: LOCK is terminal.
module rx_ber_checker #(
    parameter int NB_INPUT   = 8,
    parameter int OS_FACTOR  = 4,
    parameter int NB_PHASE   = 2,
    parameter int BUF_LEN    = 511,
    parameter int NB_LAT     = 9,
    parameter int NB_COUNT   = 64,
    parameter int RELOCK_THR = 127
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic [NB_PHASE-1:0]        i_phase,
    input  logic signed [NB_INPUT-1:0] i_sample,
    input  logic                       i_ref_bit,
    output logic                       o_locked,
    output logic [NB_LAT-1:0]          o_latency,
    output logic [NB_COUNT-1:0]        o_bit_count,
    output logic [NB_COUNT-1:0]        o_err_count,
    output logic [1:0]                 o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_LOCK   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [NB_PHASE-1:0]   phase_cnt_q, phase_cnt_d;
    // Tap 0 of the reference window is the bit arriving on the current tick, so only the
    // BUF_LEN-1 older taps need to be stored.
    logic [BUF_LEN-2:0]    ref_buf_q;
    logic [NB_LAT-1:0]     w_q, d_q, e_q, min_err_q, best_q, lat_q;
    logic [NB_COUNT-1:0]   bit_cnt_q, err_cnt_q;
`ifdef RX_RELOCK_EN
    logic [NB_LAT-1:0]     win_cnt_q, win_err_q, win_err_next;
    logic                  win_last, relock;
`endif

    logic                  tick;
    logic                  rx_bit;
    logic [BUF_LEN-1:0]    ref_now;
    logic                  search_mm, lock_mm;
    logic [NB_LAT-1:0]     e_next;
    logic                  last_w, last_d, better;

    assign phase_cnt_d = (phase_cnt_q == NB_PHASE'(OS_FACTOR - 1)) ? '0 : phase_cnt_q + 1'b1;
    assign tick        = i_enable && (phase_cnt_q == i_phase);
    // Bit 1 is sent as a negative level; zero slices to 0.
    assign rx_bit      = (i_sample < $signed(NB_INPUT'(0)));
    assign ref_now     = {ref_buf_q, i_ref_bit};
    assign search_mm   = rx_bit ^ ref_now[d_q];
    assign lock_mm     = rx_bit ^ ref_now[lat_q];
    assign e_next      = e_q + NB_LAT'(search_mm);
    assign last_w      = (w_q == NB_LAT'(BUF_LEN - 1));
    assign last_d      = (d_q == NB_LAT'(BUF_LEN - 1));
    // Strict compare: on equal error counts the earliest delay is kept.
    assign better      = (e_next < min_err_q);

`ifdef RX_RELOCK_EN
    assign win_err_next = win_err_q + NB_LAT'(lock_mm);
    assign win_last     = (win_cnt_q == NB_LAT'(BUF_LEN - 1));
    assign relock       = tick && win_last && (win_err_next > NB_LAT'(RELOCK_THR));
`endif

    // State register
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_enable) state_d = ST_FILL;
            ST_FILL:   if (tick && last_w) state_d = ST_SEARCH;
            ST_SEARCH: if (tick && last_w && last_d) state_d = ST_LOCK;
            ST_LOCK: begin
`ifdef RX_RELOCK_EN
                if (relock) state_d = ST_SEARCH;
`endif
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_state     = state_q;
        o_locked    = (state_q == ST_LOCK);
        o_latency   = lat_q;
        o_bit_count = bit_cnt_q;
        o_err_count = err_cnt_q;
    end

    // Datapath: phase counter, reference history, search and lock accumulators
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            phase_cnt_q <= '0;
            ref_buf_q   <= '0;
            w_q         <= '0;
            d_q         <= '0;
            e_q         <= '0;
            min_err_q   <= '1;
            best_q      <= '0;
            lat_q       <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
`ifdef RX_RELOCK_EN
            win_cnt_q   <= '0;
            win_err_q   <= '0;
`endif
        end else if (i_enable) begin
            phase_cnt_q <= phase_cnt_d;
            if (tick && (state_q != ST_IDLE)) begin
                ref_buf_q <= ref_now[BUF_LEN-2:0];
            end
            case (state_q)
                ST_FILL: begin
                    if (tick) begin
                        if (last_w) begin
                            w_q <= '0;
                            d_q <= '0;
                            e_q <= '0;
                        end else begin
                            w_q <= w_q + 1'b1;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (tick) begin
                        if (last_w) begin
                            if (better) begin
                                min_err_q <= e_next;
                                best_q    <= d_q;
                            end
                            if (last_d) begin
                                lat_q <= better ? d_q : best_q;
                            end
                            d_q <= last_d ? '0 : d_q + 1'b1;
                            w_q <= '0;
                            e_q <= '0;
                        end else begin
                            w_q <= w_q + 1'b1;
                            e_q <= e_next;
                        end
                    end
                end
                ST_LOCK: begin
                    if (tick) begin
                        if (bit_cnt_q != '1) bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (lock_mm && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
`ifdef RX_RELOCK_EN
                        if (win_last) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                            if (relock) begin
                                // History is still valid, so the re-search skips FILL.
                                d_q       <= '0;
                                w_q       <= '0;
                                e_q       <= '0;
                                min_err_q <= '1;
                                best_q    <= '0;
                                bit_cnt_q <= '0;
                                err_cnt_q <= '0;
                            end
                        end else begin
                            win_cnt_q <= win_cnt_q + 1'b1;
                            win_err_q <= win_err_next;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rx_ber_checker.md
Name: rx_ber_checker

Overview:
- Receive-side end of the TX chain (PRBS QI generator -> polyphase shaping FIR).
- Takes the oversampled, filtered symbol stream of one branch (I or Q) and decimates it at a selectable phase.
- Hard-slices each symbol to a bit, searches for the latency between the received bits and the reference PRBS bits, then accumulates bit and error counts for BER measurement.
- One instance per branch; it sits beside the TX top in the loopback test system.

Parameters:
- NB_INPUT, 8, width of the signed input sample, S(8,6).
- OS_FACTOR, 4, oversampling factor (clocks per symbol when i_enable is held high).
- NB_PHASE, 2, width of the phase select; log2(OS_FACTOR).
- BUF_LEN, 511, reference buffer depth = search range = search window length in symbols.
- NB_LAT, 9, width of the latency and window indexes; ceil(log2(BUF_LEN)).
- NB_COUNT, 64, width of the bit and error accumulators.
- RELOCK_THR, 127, window error count above which the block re-searches (optional feature only).

Ports:
- clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  processing enable; low freezes all state.
- i_phase  in  NB_PHASE  decimation phase, 0..OS_FACTOR-1.
- i_sample  in  NB_INPUT  signed filtered sample.
- i_ref_bit  in  1  reference PRBS bit; sampled on the symbol tick.
- o_locked  out  1  high in LOCK state.
- o_latency  out  NB_LAT  selected delay in symbols.
- o_bit_count  out  NB_COUNT  symbols compared while locked.
- o_err_count  out  NB_COUNT  mismatches while locked.
- o_state  out  2  FSM state: 0 IDLE, 1 FILL, 2 SEARCH, 3 LOCK.

Behaviour:
- Reset is asynchronous and active-low: i_reset=0 clears everything immediately, including mid-operation. After reset:
  - all outputs are 0;
  - phase counter = 0;
  - reference buffer is all zeros;
  - min_err = all ones;
  - FSM is in IDLE.
- Phase counter:
  - increments modulo OS_FACTOR on each clock with i_enable=1;
  - symbol tick = i_enable && (counter == i_phase);
  - an i_phase change takes effect on the next counter match; no glitch tick is generated.
- Slicer, evaluated on the tick only:
  - rx_bit = 1 if i_sample < 0, else 0;
  - i_sample = 0 slices to 0.
  - Mapping matches the TX: bit 1 maps to a negative level.
- Reference buffer:
  - shift register of BUF_LEN bits, written with i_ref_bit on every tick in every state except IDLE;
  - ref_buf[d] is the reference bit d symbols before the current one.
- i_enable=0 holds the counter, buffer, FSM and all accumulators.
- FSM:
  - IDLE -> FILL on the first clock with i_enable=1.
  - FILL:
    - counts BUF_LEN ticks, with no comparisons;
    - -> SEARCH with d=0, w=0, e=0.
  - SEARCH, on each tick:
    - e += (rx_bit != ref_buf[d]); w++.
    - On the tick where w == BUF_LEN-1, the final e includes that tick's comparison.
    - If final e < min_err (strict), then min_err <= e and best <= d; ties keep the earliest d.
    - Then d++, w=0, e=0.
    - After the d = BUF_LEN-1 window completes: o_latency <= best, -> LOCK, o_locked=1.
    - The full sweep is always performed (BUF_LEN*BUF_LEN ticks); there is no early exit.
  - LOCK, on each tick:
    - o_bit_count++;
    - o_err_count += (rx_bit != ref_buf[o_latency]).
    - Both counters saturate at all ones; they do not wrap.
    - LOCK is left only by reset (or by the optional feature).
- Latency:
  - o_locked, o_latency and o_state update on the clock edge after the tick that completes the last window;
  - counters update 1 clock after their tick.

Optional Feature:
- RX_RELOCK_EN defined:
  - in LOCK, a window counter of BUF_LEN ticks accumulates window errors;
  - if the window total exceeds RELOCK_THR at window end:
    - -> SEARCH (buffer already valid, no FILL);
    - o_locked=0;
    - d, w, e cleared; min_err = all ones;
    - o_bit_count and o_err_count cleared to 0.
- RX_RELOCK_EN undefined:
  - no window counter exists;
  - LOCK is terminal until reset.

Test Plan:
1. Reference PRBS9 (x^9+x^5+1), i_sample = +32 for bit 0 and -32 for bit 1, rx delayed 7 symbols, i_phase=2, i_enable=1 -> o_state sequence 1,2,3; LOCK after 511 + 511*511 ticks; o_latency=7; o_err_count=0; o_bit_count increments once per 4 clocks.
2. As scenario 1, with every 100th rx symbol sign-inverted after lock -> o_err_count = floor(o_bit_count/100) ±1; o_latency remains 7.
3. i_sample=0 on all symbols, reference all zeros -> rx_bit=0; lock at o_latency=0 (earliest tie); o_err_count=0.
4. i_reset pulled low for 20 ns mid-SEARCH -> all outputs 0 immediately; o_state=0; after release a full FILL + SEARCH repeats.
5. i_enable low for 1000 clocks while in LOCK -> o_bit_count and o_err_count frozen; counting resumes on the same phase after i_enable returns high.
6. RX_RELOCK_EN defined; after lock, rx delay changed from 7 to 20 -> window errors ≈255 > 127; o_locked=0; counters cleared; re-lock with o_latency=20.
